// File: rtl/char_string_render.sv
// char_string_render: draws a NUM_CHARS-glyph string from a 5x7 font at
// 2**SCALE_LOG2 scale. Placement and text are latched on frame_tick so the
// picture never tears. Fixed 2-cycle latency from x/y to display.
// Optional feature macro: BLINK_EN (frame-counted blink masking).
module char_string_render #(
   parameter int NUM_CHARS    = 8,
   parameter int SCALE_LOG2   = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [9:0]             start_x,
   input  logic [9:0]             start_y,
   input  logic [5*NUM_CHARS-1:0] text,
   input  logic                   blink,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   output logic                   display
);

   localparam int          CELL  = 1 << SCALE_LOG2;
   localparam logic [10:0] BOX_W = 11'(NUM_CHARS * 6 * CELL);
   localparam logic [10:0] BOX_H = 11'(7 * CELL);

   // 5x7 glyph rows packed row 0 first (MSBs); bit 4 of a row is the leftmost column
   function automatic logic [34:0] font_rom(input logic [4:0] code);
      case (code)
         5'd0:  font_rom = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
         5'd1:  font_rom = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
         5'd2:  font_rom = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
         5'd3:  font_rom = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
         5'd4:  font_rom = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
         5'd5:  font_rom = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
         5'd6:  font_rom = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
         5'd7:  font_rom = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
         5'd8:  font_rom = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
         5'd9:  font_rom = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
         5'd10: font_rom = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001}; // A
         5'd11: font_rom = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111}; // E
         5'd12: font_rom = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111}; // G
         5'd13: font_rom = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110}; // I
         5'd14: font_rom = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111}; // L
         5'd15: font_rom = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001}; // M
         5'd16: font_rom = {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001}; // N
         5'd17: font_rom = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110}; // O
         5'd18: font_rom = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000}; // P
         5'd19: font_rom = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10100, 5'b10010, 5'b10001}; // R
         5'd20: font_rom = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110}; // S
         5'd21: font_rom = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100}; // V
         5'd22: font_rom = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010}; // W
         5'd23: font_rom = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100}; // Y
         5'd24: font_rom = {5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000}; // :
         default: font_rom = '0;
      endcase
   endfunction

   logic [9:0]             sx_q, sy_q;
   logic [5*NUM_CHARS-1:0] txt_q;

   // Shadow placement/text, only updated at frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         sx_q  <= '0;
         sy_q  <= '0;
         txt_q <= '1;
      end else if (frame_tick) begin
         sx_q  <= start_x;
         sy_q  <= start_y;
         txt_q <= text;
      end
   end

   // Stage 1: box test and cell coordinates, sums widened so boxes clip rather than wrap.
   // The character code is picked here so a pixel sharing a cycle with frame_tick
   // sees the old text as well as the old placement.
   logic [10:0] dx, dy, cx, idx;
   logic        in_box_d, in_box_q;
   logic [4:0]  code_d, code_q;
   logic [2:0]  col_d, col_q, row_d, row_q;

   // Stage 1 combinational decode
   always_comb begin
      dx       = {1'b0, x} - {1'b0, sx_q};
      dy       = {1'b0, y} - {1'b0, sy_q};
      in_box_d = (x >= sx_q) && ({1'b0, x} < ({1'b0, sx_q} + BOX_W)) &&
                 (y >= sy_q) && ({1'b0, y} < ({1'b0, sy_q} + BOX_H));
      cx       = dx >> SCALE_LOG2;
      row_d    = 3'(dy >> SCALE_LOG2);
      idx      = cx / 11'd6;
      col_d    = 3'(cx % 11'd6);
      code_d   = 5'd31;
      for (int i = 0; i < NUM_CHARS; i++)
         if (idx == 11'(i)) code_d = txt_q[5*i +: 5];
   end

   // Stage 1 register
   always_ff @(posedge clk) begin
      if (reset) begin
         in_box_q <= 1'b0;
         code_q   <= 5'd31;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         in_box_q <= in_box_d;
         code_q   <= code_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   logic mask;

`ifdef BLINK_EN
   logic [7:0] bcnt_q;
   logic       phase_q;

   // Blink phase toggles every BLINK_FRAMES frame ticks, starting visible
   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt_q  <= '0;
         phase_q <= 1'b1;
      end else if (frame_tick) begin
         if (bcnt_q == 8'(BLINK_FRAMES - 1)) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            bcnt_q  <= bcnt_q + 8'd1;
         end
      end
   end

   assign mask = blink & ~phase_q;
`else
   logic blink_unused;
   assign blink_unused = blink;
   assign mask         = 1'b0;
`endif

   // Stage 2: font lookup; gap column and invalid rows stay dark
   logic [34:0] glyph;
   logic [4:0]  row_bits, shifted;
   logic        display_d, display_q;

   // Stage 2 combinational pixel select
   always_comb begin
      glyph    = font_rom(code_q);
      row_bits = '0;
      for (int r = 0; r < 7; r++)
         if (row_q == 3'(r)) row_bits = glyph[5*(6-r) +: 5];
      shifted   = 5'(row_bits << col_q);
      display_d = in_box_q && (col_q < 3'd5) && shifted[4] && !mask;
   end

   // Stage 2 register
   always_ff @(posedge clk) begin
      if (reset) display_q <= 1'b0;
      else       display_q <= display_d;
   end

   assign display = display_q;

endmodule

// File: tb/tb_char_string_render.sv
// Bench for char_string_render: hand tables, multi-cycle corner sequences and
// random frames checked against a pixel-level reference model.
module tb_char_string_render;

   localparam int NC   = 8;
   localparam int SL   = 2;
   localparam int BF   = 2;
   localparam int CELL = 1 << SL;
   localparam int W    = NC * 6 * CELL;
   localparam int H    = 7 * CELL;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            frame_tick = 1'b0;
   logic [9:0]      start_x = '0, start_y = '0, x = '0, y = '0;
   logic [5*NC-1:0] text = '0;
   logic            blink = 1'b0;
   logic            display;

   char_string_render #(.NUM_CHARS(NC), .SCALE_LOG2(SL), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_x(start_x),
      .start_y(start_y), .text(text), .blink(blink), .x(x), .y(y), .display(display));

   always #5 clk = ~clk;

   int    n_cmp = 0, n_bad = 0;
   int    m_sx, m_sy, m_ticks;
   int    m_txt[NC];
   bit    prev_vld = 0;
   bit    prev_exp;
   string prev_name;

   // Glyph pictures, '#' = lit, row 0 first
   function automatic string glyph(input int code);
      case (code)
         0:  return {".###.","#...#","#..##","#.#.#","##..#","#...#",".###."};
         1:  return {"..#..",".##..","..#..","..#..","..#..","..#..",".###."};
         2:  return {".###.","#...#","....#","...#.","..#..",".#...","#####"};
         3:  return {"#####","...#.","..#..","...#.","....#","#...#",".###."};
         4:  return {"...#.","..##.",".#.#.","#..#.","#####","...#.","...#."};
         5:  return {"#####","#....","####.","....#","....#","#...#",".###."};
         6:  return {"..##.",".#...","#....","####.","#...#","#...#",".###."};
         7:  return {"#####","....#","...#.","..#..",".#...",".#...",".#..."};
         8:  return {".###.","#...#","#...#",".###.","#...#","#...#",".###."};
         9:  return {".###.","#...#","#...#",".####","....#","...#.",".##.."};
         10: return {".###.","#...#","#...#","#####","#...#","#...#","#...#"};
         11: return {"#####","#....","#....","####.","#....","#....","#####"};
         12: return {".###.","#...#","#....","#.###","#...#","#...#",".####"};
         13: return {".###.","..#..","..#..","..#..","..#..","..#..",".###."};
         14: return {"#....","#....","#....","#....","#....","#....","#####"};
         15: return {"#...#","##.##","#.#.#","#.#.#","#...#","#...#","#...#"};
         16: return {"#...#","#...#","##..#","#.#.#","#..##","#...#","#...#"};
         17: return {".###.","#...#","#...#","#...#","#...#","#...#",".###."};
         18: return {"####.","#...#","#...#","####.","#....","#....","#...."};
         19: return {"####.","#...#","#...#","####.","#.#..","#..#.","#...#"};
         20: return {".####","#....","#....",".###.","....#","....#","####."};
         21: return {"#...#","#...#","#...#","#...#","#...#",".#.#.","..#.."};
         22: return {"#...#","#...#","#...#","#.#.#","#.#.#","#.#.#",".#.#."};
         23: return {"#...#","#...#",".#.#.","..#..","..#..","..#..","..#.."};
         24: return {".....","..#..",".....",".....",".....","..#..","....."};
         default: return {".....",".....",".....",".....",".....",".....","....."};
      endcase
   endfunction

   function automatic bit model_lit(input int px, input int py);
      int cx, r, c;
      string g;
      if (px < m_sx || px >= m_sx + W || py < m_sy || py >= m_sy + H) return 0;
      cx = (px - m_sx) / CELL;
      r  = (py - m_sy) / CELL;
      c  = cx % 6;
      if (c == 5) return 0;
      g = glyph(m_txt[cx / 6]);
      return g[r*5 + c] == 8'd35;
   endfunction

   task automatic check(input string name, input logic act, input bit exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: display=%b expected %0b", name, act, exp);
      end
   endtask

   // One pixel per cycle; the result for a pixel is checked one edge after its
   // stage-1 edge, i.e. two clocks after it was presented.
   task automatic step(input int px, input int py, input bit ft, input bit rst,
                       input int want, input string name);
      bit e;
      @(negedge clk);
      x = 10'(px); y = 10'(py); frame_tick = ft; reset = rst;
      e = rst ? 1'b0 : model_lit(px, py);
      if (rst) begin
         m_sx = 0; m_sy = 0; m_ticks = 0;
         for (int i = 0; i < NC; i++) m_txt[i] = 31;
      end else if (ft) begin
         m_sx = int'(start_x); m_sy = int'(start_y); m_ticks++;
         for (int i = 0; i < NC; i++) m_txt[i] = int'(text[5*i +: 5]);
      end
`ifdef BLINK_EN
      if (blink && ((m_ticks / BF) % 2 == 1)) e = 0;
`endif
      if (want >= 0) e = (want != 0);
      @(posedge clk); #1;
      if (prev_vld) check(prev_name, display, rst ? 1'b0 : prev_exp);
      prev_vld = 1; prev_exp = e; prev_name = name;
   endtask

   task automatic load(input int sxv, input int syv, input logic [5*NC-1:0] t);
      start_x = 10'(sxv); start_y = 10'(syv); text = t;
      step(0, 0, 1, 0, -1, "load");
   endtask

   typedef struct { int px; int py; bit exp; string name; } vec_t;
   vec_t vecs[$];

   logic [5*NC-1:0] seq_txt;
   int fx, fy;

   initial begin
      // glyph codes 0..7 left to right
      seq_txt = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
      vecs = '{
         '{104, 50, 1, "c0_row0_col1"},   '{100, 50, 0, "c0_row0_col0"},
         '{120, 54, 0, "gap_x120"},       '{121, 54, 0, "gap_x121"},
         '{122, 54, 0, "gap_x122"},       '{123, 54, 0, "gap_x123"},
         '{ 99, 50, 0, "left_of_box"},    '{104, 78, 0, "below_box"},
         '{104, 77, 1, "c0_last_row"},    '{100, 54, 1, "c0_row1_col0"},
         '{132, 50, 1, "c1_row0_col2"},   '{128, 50, 0, "c1_row0_col1"},
         '{160, 62, 1, "c2_row3_col3"},   '{268, 50, 1, "c7_row0_col0"},
         '{284, 50, 1, "c7_row0_col4"},   '{288, 50, 0, "c7_gap"},
         '{292, 50, 0, "right_of_box"}
      };

      // reset state
      step(104, 50, 0, 1, -1, "reset");
      check("reset_display", display, 1'b0);
      step(104, 50, 0, 1, -1, "reset2");
      step(104, 50, 0, 0, 0, "blank_after_reset");
      step(104, 50, 0, 0, 0, "blank_after_reset2");

      // basic placement table
      load(100, 50, seq_txt);
      foreach (vecs[i]) step(vecs[i].px, vecs[i].py, 0, 0, int'(vecs[i].exp), vecs[i].name);

      // mid-frame changes ignored until frame_tick; tick pixel uses old values
      start_x = 10'd300; text = {NC{5'd8}};
      step(104, 50, 0, 0, 1, "no_tick_hold");
      step(304, 50, 0, 0, 0, "no_tick_new_pos_dark");
      step(104, 50, 1, 0, 1, "tick_pixel_old");
      step(104, 50, 0, 0, 0, "after_tick_old_pos");
      step(304, 50, 0, 0, 1, "after_tick_new_glyph");
      step(300, 50, 0, 0, 0, "after_tick_col0");

      // right/bottom edge and no wrap of the box sums
      load(630, 475, seq_txt);
      step(634, 475, 0, 0, 1, "edge_x634");
      step(629, 475, 0, 0, 0, "edge_x629");
      step(630, 479, 0, 0, 1, "edge_row1_col0");
      step(  4, 475, 0, 0, 0, "edge_nowrap_x4");
      for (int px = 600; px < 640; px++) step(px, 476, 0, 0, -1, "edge_scan");
      load(1000, 100, seq_txt);
      step(1004, 100, 0, 0, 1, "wide_sum_x1004");
      step(   4, 100, 0, 0, 0, "wide_sum_x4");

      // reset while in box: clears both stages and the text
      load(100, 50, seq_txt);
      step(104, 50, 0, 0, 1, "pre_reset_lit");
      step(104, 50, 0, 0, 1, "pre_reset_lit2");
      step(104, 50, 0, 1, 0, "mid_reset");
      step(104, 50, 0, 0, 0, "post_reset1");
      step(104, 50, 0, 0, 0, "post_reset2");
      step(104, 50, 0, 0, 0, "post_reset3");
      load(100, 50, seq_txt);
      step(104, 50, 0, 0, 1, "reload_lit");

      // blink: frame count since reset decides the phase
      step(0, 0, 0, 1, -1, "blink_reset");
      start_x = 10'd100; start_y = 10'd50; text = seq_txt;
      blink = 1'b1;
      for (int f = 1; f <= 6; f++) begin
         bit w;
`ifdef BLINK_EN
         w = ((f / BF) % 2) == 0;
`else
         w = 1'b1;
`endif
         step(0, 0, 1, 0, -1, "blink_tick");
         step(104, 50, 0, 0, int'(w), $sformatf("blink_on_f%0d", f));
         step(104, 50, 0, 0, int'(w), $sformatf("blink_on_f%0d_b", f));
         step(0, 0, 0, 0, 0, "blink_off_box");
      end
      blink = 1'b0;
      for (int f = 7; f <= 8; f++) begin
         step(0, 0, 1, 0, -1, "noblink_tick");
         step(104, 50, 0, 0, 1, $sformatf("noblink_f%0d", f));
         step(0, 0, 0, 0, 0, "noblink_off_box");
      end

      // random frames against the model, with occasional mid-frame reloads
      for (int fr = 0; fr < 20; fr++) begin
         logic [5*NC-1:0] t;
         for (int i = 0; i < NC; i++) t[5*i +: 5] = 5'($urandom_range(0, 31));
         load(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), t);
         for (int p = 0; p < 200; p++) begin
            bit ft;
            fx = (m_sx + int'($urandom_range(0, W + 7)) + 1020) % 1024;
            fy = (m_sy + int'($urandom_range(0, H + 7)) + 1020) % 1024;
            ft = ($urandom_range(0, 63) == 0);
            if (ft) begin
               start_x = 10'(m_sx + int'($urandom_range(0, 8)));
               start_y = 10'(m_sy);
               for (int i = 0; i < NC; i++) text[5*i +: 5] = 5'($urandom_range(0, 31));
            end
            step(fx, fy, ft, 0, -1, "random");
         end
      end
      step(0, 0, 0, 0, 0, "flush");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
